mux_n_scan_reg: RTL and testbench
=================================

// Module: mux_n_scan_reg
// PURPOSE
//  Parametrised N-channel, WIDTH-bit multiplexer with registered output and valid/ready handshake.
//  Two modes: direct (channel chosen by S) and auto-scan (internal counter steps through channels).
//  Feeds display/datapath consumers that sample one channel at a time and may stall.
//  Generalises the 8:1 x 4-bit mux family to arbitrary width/channel count, adds sequencing and flow control.
// PARAMETERS
//  WIDTH     4   bits per channel
//  CHANNELS  8   number of input channels, >=2; need not be a power of two
//  SELW      3   select width, must equal $clog2(CHANNELS)
//  DWELL     1   scan mode: accepted transfers per channel before advancing, >=1
// PORTS
//  Clock    in   1                 single clock, rising edge
//  Reset    in   1                 synchronous, active-high
//  W        in   CHANNELS*WIDTH    flattened channel data; channel k = W[k*WIDTH +: WIDTH]
//  S        in   SELW              direct-mode channel select
//  Mode     in   1                 0 = direct, 1 = auto-scan
//  En       in   1                 capture request; no capture when low
//  F        out  WIDTH             registered selected data
//  F_ch     out  SELW              channel index that produced F
//  F_valid  out  1                 F/F_ch hold a word not yet consumed
//  F_ready  in   1                 consumer accepts F when F_valid & F_ready
//  Sel_err  out  1                 registered; F was captured from an out-of-range S
// BEHAVIOUR
//  Reset (sync, active-high; wins over all other inputs): F=0, F_ch=0, F_valid=0, Sel_err=0,
//   scan counter Ch=0, dwell counter=0, state EMPTY.
//  FSM: EMPTY (F_valid=0) and FULL (F_valid=1).
//   EMPTY: En=1 -> capture, go FULL. En=0 -> stay.
//   FULL: F_ready=1 & En=1 -> capture new word the same cycle, stay FULL (no bubble).
//         F_ready=1 & En=0 -> go EMPTY. F_ready=0 -> hold F, F_ch, Sel_err; W/S changes ignored.
//  capture = En & (state==EMPTY | F_ready). Latency: W/S at edge t appear on F after edge t (1 cycle).
//  Channel chosen at capture: direct -> S; scan -> Ch.
//  Out-of-range S (S>=CHANNELS, only if CHANNELS not a power of two): F=0, F_ch=S, Sel_err=1.
//   Sel_err clears on the next in-range capture.
//  Scan: dwell counter increments on each scan-mode capture. When it reaches DWELL-1, it resets to 0
//   and Ch advances; CHANNELS-1 wraps to 0.
//   Ch and dwell do not advance on stalls, on En=0, or in direct mode.
//  Mode change: Mode is sampled each cycle. On a 0->1 edge (registered previous Mode), Ch and dwell
//   reload to 0, and any capture in that cycle uses channel 0.
//   1->0: the counter freezes; the next 0->1 restarts from 0.
//  Sampled W is not held: a stalled word keeps its captured value, not live W.
//  Reset mid-transfer drops the pending word (F_valid=0 next cycle) regardless of F_ready.
// CONFIGURATION
//  MUX_SCAN_PARITY_EN defined: extra output F_par (1 bit) = even parity (^F) of each captured word.
//   Registered with F and held during stalls; 0 on reset. Same latency.
//  Not defined: F_par port absent; no parity logic.
// TESTING
//  1 Reset: assert Reset 2 cycles while En=1 -> F=0, F_valid=0, Sel_err=0, F_ch=0.
//  2 Direct, W ch5=4'hA, S=5, En=1, F_ready=1 -> next cycle F=4'hA, F_ch=5, F_valid=1; S=2 (ch2=4'h3) -> F=4'h3.
//  3 Backpressure: F valid at 4'hA, F_ready=0 for 3 cycles while W/S change -> F stays 4'hA, F_ch=5;
//    F_ready=1 -> new word the same cycle, no bubble.
//  4 Scan, DWELL=1, CHANNELS=8, En=1, F_ready=1 -> F_ch 0,1,...,7,0; stall mid-sequence -> no channel skipped.
//  5 CHANNELS=6, SELW=3, direct S=7 -> F=0, Sel_err=1, F_ch=7; then S=1 -> Sel_err=0.
//  6 Scan at Ch=4, Mode 1->0->1 -> first scan capture is ch0; Reset while FULL & F_ready=0 -> F_valid=0.

Source files
------------

// File: rtl/mux_n_scan_reg_if.sv
// Bus bundle for mux_n_scan_reg: channel data, select/mode/capture controls
// and the registered output word with its valid/ready handshake.
// Optional MUX_SCAN_PARITY_EN adds the f_par output bit.
//
// Handshake: f_valid high means f/f_ch/sel_err(/f_par) hold a word not yet
// consumed; the word is transferred on a rising clk edge where
// f_valid & f_ready are both high. While f_valid is high and f_ready is low
// the producer holds every output field stable. f_valid never depends
// combinationally on f_ready.
interface mux_n_scan_reg_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 8,
    parameter int SELW     = 3
);
    logic [CHANNELS*WIDTH-1:0] w;
    logic [SELW-1:0]           s;
    logic                      mode;
    logic                      en;
    logic [WIDTH-1:0]          f;
    logic [SELW-1:0]           f_ch;
    logic                      f_valid;
    logic                      f_ready;
    logic                      sel_err;
`ifdef MUX_SCAN_PARITY_EN
    logic                      f_par;
`endif

    // Mux side: consumes channel data and controls, produces the word.
    modport slave (
        input  w, s, mode, en, f_ready,
        output f, f_ch, f_valid, sel_err
`ifdef MUX_SCAN_PARITY_EN
        , output f_par
`endif
    );

    // Environment side: drives data/controls and consumes the word.
    modport master (
        output w, s, mode, en, f_ready,
        input  f, f_ch, f_valid, sel_err
`ifdef MUX_SCAN_PARITY_EN
        , input f_par
`endif
    );
endinterface

// File: rtl/mux_n_scan_reg.sv
// N-channel WIDTH-bit multiplexer with a one-word registered output stage.
// Direct mode picks the channel from s; auto-scan mode walks an internal
// channel counter, staying DWELL accepted transfers on each channel.
// Optional feature macro: MUX_SCAN_PARITY_EN (adds even-parity bit f_par).
// dbg_state exposes the output-stage FSM state (0 = EMPTY, 1 = FULL).
module mux_n_scan_reg #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 8,
    parameter int SELW     = 3,
    parameter int DWELL    = 1
) (
    input  logic              clk,
    input  logic              rst,
    mux_n_scan_reg_if.slave   bus,
    output logic              dbg_state
);

    localparam int DWW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SELW:0]   CH_COUNT   = (SELW+1)'(CHANNELS);
    localparam logic [SELW-1:0] CH_LAST    = SELW'(CHANNELS - 1);
    localparam logic [DWW-1:0]  DWELL_LAST = DWW'(DWELL - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic [SELW-1:0]  ch;
    logic [DWW-1:0]   dwell;
    logic             mode_q;
    logic [WIDTH-1:0] f_q;
    logic [SELW-1:0]  f_ch_q;
    logic             sel_err_q;

    logic             mode_rise;
    logic             capture;
    logic [SELW-1:0]  ch_base;
    logic [DWW-1:0]   dwell_base;
    logic [SELW-1:0]  sel;
    logic             in_range;
    logic [WIDTH-1:0] sel_data;
    logic [SELW-1:0]  ch_next;
    logic [DWW-1:0]   dwell_next;

    // Capture decision, channel choice and next scan position.
    always_comb begin
        mode_rise  = bus.mode & ~mode_q;
        capture    = bus.en & ((state == EMPTY) | bus.f_ready);
        // A fresh entry into scan mode restarts the walk at channel 0 and
        // the capture in that same cycle already uses the restarted value.
        ch_base    = mode_rise ? '0 : ch;
        dwell_base = mode_rise ? '0 : dwell;
        sel        = bus.mode ? ch_base : bus.s;
        // Only reachable as false when CHANNELS is not a power of two.
        in_range   = {1'b0, sel} < CH_COUNT;

        sel_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel == SELW'(k)) begin
                sel_data = bus.w[k*WIDTH +: WIDTH];
            end
        end

        ch_next    = ch_base;
        dwell_next = dwell_base;
        if (capture && bus.mode) begin
            if (dwell_base == DWELL_LAST) begin
                dwell_next = '0;
                ch_next    = (ch_base == CH_LAST) ? '0 : ch_base + 1'b1;
            end else begin
                dwell_next = dwell_base + 1'b1;
            end
        end
    end

    // Output-stage FSM plus all registered outputs and scan counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            f_q       <= '0;
            f_ch_q    <= '0;
            sel_err_q <= 1'b0;
            ch        <= '0;
            dwell     <= '0;
            mode_q    <= 1'b0;
        end else begin
            mode_q <= bus.mode;
            ch     <= ch_next;
            dwell  <= dwell_next;
            case (state)
                EMPTY: if (capture) state <= FULL;
                FULL:  if (bus.f_ready && !bus.en) state <= EMPTY;
                default: state <= EMPTY;
            endcase
            if (capture) begin
                f_q       <= in_range ? sel_data : '0;
                f_ch_q    <= sel;
                sel_err_q <= ~in_range;
            end
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    logic f_par_q;

    // Even parity of the captured word, held alongside it during stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_par_q <= 1'b0;
        end else if (capture) begin
            f_par_q <= in_range ? ^sel_data : 1'b0;
        end
    end

    assign bus.f_par = f_par_q;
`endif

    assign bus.f       = f_q;
    assign bus.f_ch    = f_ch_q;
    assign bus.sel_err = sel_err_q;
    assign bus.f_valid = (state == FULL);
    assign dbg_state   = state;

endmodule

// File: tb/tb_mux_n_scan_reg.sv
// Bench for mux_n_scan_reg: dut_a is 8 channels / DWELL 1, dut_b is
// 6 channels / DWELL 2 (exercises out-of-range selects and dwell).
module tb_mux_n_scan_reg;

    localparam int A_CH = 8;
    localparam int A_DW = 1;
    localparam int B_CH = 6;
    localparam int B_DW = 2;

    logic clk = 1'b0;
    logic rst;
    logic dbg_a, dbg_b;
    int   checks   = 0;
    int   failures = 0;

    // Expected pending word: {sel_err, f_ch[2:0], f[3:0]}
    logic [7:0] exp_a_q[$];
    logic [7:0] exp_b_q[$];
    int   a_pos, b_pos;
    logic a_prev, b_prev;

    always #5 clk = ~clk;

    mux_n_scan_reg_if #(.WIDTH(4), .CHANNELS(A_CH), .SELW(3)) if_a ();
    mux_n_scan_reg_if #(.WIDTH(4), .CHANNELS(B_CH), .SELW(3)) if_b ();

    mux_n_scan_reg #(.WIDTH(4), .CHANNELS(A_CH), .SELW(3), .DWELL(A_DW)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a.slave), .dbg_state(dbg_a));

    mux_n_scan_reg #(.WIDTH(4), .CHANNELS(B_CH), .SELW(3), .DWELL(B_DW)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b.slave), .dbg_state(dbg_b));

    // Reference model A: a one-deep word buffer; the scan channel is derived
    // from the number of scan captures since the last scan restart.
    always @(posedge clk) begin : model_a
        logic full, cap;
        int   c;
        logic [3:0] d;
        if (rst) begin
            exp_a_q.delete();
            a_pos  = 0;
            a_prev = 1'b0;
        end else begin
            full = (exp_a_q.size() != 0);
            if (if_a.mode && !a_prev) a_pos = 0;
            cap = if_a.en && (!full || if_a.f_ready);
            if (full && if_a.f_ready) void'(exp_a_q.pop_front());
            if (cap) begin
                if (if_a.mode) begin
                    c = (a_pos / A_DW) % A_CH;
                    a_pos++;
                end else begin
                    c = int'(if_a.s);
                end
                d = (c < A_CH) ? if_a.w[c*4 +: 4] : 4'h0;
                exp_a_q.push_back({(c >= A_CH), 3'(c), d});
            end
            a_prev = if_a.mode;
        end
    end

    // Reference model B, same rules with its own geometry.
    always @(posedge clk) begin : model_b
        logic full, cap;
        int   c;
        logic [3:0] d;
        if (rst) begin
            exp_b_q.delete();
            b_pos  = 0;
            b_prev = 1'b0;
        end else begin
            full = (exp_b_q.size() != 0);
            if (if_b.mode && !b_prev) b_pos = 0;
            cap = if_b.en && (!full || if_b.f_ready);
            if (full && if_b.f_ready) void'(exp_b_q.pop_front());
            if (cap) begin
                if (if_b.mode) begin
                    c = (b_pos / B_DW) % B_CH;
                    b_pos++;
                end else begin
                    c = int'(if_b.s);
                end
                d = (c < B_CH) ? if_b.w[c*4 +: 4] : 4'h0;
                exp_b_q.push_back({(c >= B_CH), 3'(c), d});
            end
            b_prev = if_b.mode;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_a.en = 1'b1; if_a.f_ready = 1'b1; if_a.mode = 1'b0; if_a.s = 3'd3;
        if_b.en = 1'b1; if_b.f_ready = 1'b1; if_b.mode = 1'b0; if_b.s = 3'd3;
        if_a.w = 32'($urandom); if_b.w = 24'($urandom);
        cycle();
        cycle();
        checks++; if (if_a.f !== 4'h0) begin failures++; $display("FAIL reset_f: got %0h want 0", if_a.f); end
        checks++; if (if_a.f_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", if_a.f_valid); end
        checks++; if (if_a.sel_err !== 1'b0) begin failures++; $display("FAIL reset_sel_err: got %0b want 0", if_a.sel_err); end
        checks++; if (if_a.f_ch !== 3'd0) begin failures++; $display("FAIL reset_f_ch: got %0d want 0", if_a.f_ch); end
        checks++;
        if ({if_b.f_valid, if_b.sel_err, if_b.f_ch, if_b.f} !== 9'h0) begin
            failures++;
            $display("FAIL reset_b: got v=%0b e=%0b ch=%0d f=%0h want all 0", if_b.f_valid, if_b.sel_err, if_b.f_ch, if_b.f);
        end
        rst = 1'b0;
        if_a.en = 1'b0;
        if_b.en = 1'b0;
    endtask

    task automatic test_direct();
        if_a.mode = 1'b0; if_a.f_ready = 1'b1; if_a.en = 1'b1;
        if_a.w = 32'($urandom); if_a.w[5*4 +: 4] = 4'hA; if_a.s = 3'd5;
        cycle();
        checks++;
        if (if_a.f !== 4'hA || if_a.f_ch !== 3'd5 || if_a.f_valid !== 1'b1 || if_a.sel_err !== 1'b0) begin
            failures++;
            $display("FAIL direct_ch5: got f=%0h ch=%0d v=%0b e=%0b want f=a ch=5 v=1 e=0", if_a.f, if_a.f_ch, if_a.f_valid, if_a.sel_err);
        end
        if_a.w = 32'($urandom); if_a.w[2*4 +: 4] = 4'h3; if_a.s = 3'd2;
        cycle();
        checks++;
        if (if_a.f !== 4'h3 || if_a.f_ch !== 3'd2 || if_a.f_valid !== 1'b1) begin
            failures++;
            $display("FAIL direct_ch2: got f=%0h ch=%0d v=%0b want f=3 ch=2 v=1", if_a.f, if_a.f_ch, if_a.f_valid);
        end
    endtask

    task automatic test_backpressure();
        if_a.mode = 1'b0; if_a.f_ready = 1'b1; if_a.en = 1'b1;
        if_a.w = 32'($urandom); if_a.w[5*4 +: 4] = 4'hA; if_a.s = 3'd5;
        cycle();
        if_a.f_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if_a.w = 32'($urandom);
            if_a.s = 3'($urandom_range(7));
            cycle();
            checks++;
            if (if_a.f !== 4'hA || if_a.f_ch !== 3'd5 || if_a.f_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got f=%0h ch=%0d v=%0b want f=a ch=5 v=1", i, if_a.f, if_a.f_ch, if_a.f_valid);
            end
        end
        if_a.f_ready = 1'b1;
        if_a.w = 32'($urandom); if_a.w[2*4 +: 4] = 4'h3; if_a.s = 3'd2;
        cycle();
        checks++;
        if (if_a.f !== 4'h3 || if_a.f_ch !== 3'd2 || if_a.f_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: got f=%0h ch=%0d v=%0b want f=3 ch=2 v=1", if_a.f, if_a.f_ch, if_a.f_valid);
        end
    endtask

    task automatic test_scan();
        logic [31:0] snap;
        if_a.mode = 1'b1; if_a.en = 1'b1; if_a.f_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if_a.w = 32'($urandom); if_a.s = 3'($urandom_range(7));
            snap = if_a.w;
            cycle();
            checks++;
            if (if_a.f_ch !== 3'(i % 8) || if_a.f !== snap[(i%8)*4 +: 4] || if_a.f_valid !== 1'b1) begin
                failures++;
                $display("FAIL scan_seq[%0d]: got ch=%0d f=%0h v=%0b want ch=%0d f=%0h v=1", i, if_a.f_ch, if_a.f, if_a.f_valid, i % 8, snap[(i%8)*4 +: 4]);
            end
        end
        if_a.f_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if_a.w = 32'($urandom);
            cycle();
            checks++;
            if (if_a.f_ch !== 3'd0 || if_a.f_valid !== 1'b1) begin
                failures++;
                $display("FAIL scan_stall[%0d]: got ch=%0d v=%0b want ch=0 v=1", i, if_a.f_ch, if_a.f_valid);
            end
        end
        if_a.f_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            if_a.w = 32'($urandom);
            snap = if_a.w;
            cycle();
            checks++;
            if (if_a.f_ch !== 3'(i) || if_a.f !== snap[i*4 +: 4]) begin
                failures++;
                $display("FAIL scan_resume[%0d]: got ch=%0d f=%0h want ch=%0d f=%0h", i, if_a.f_ch, if_a.f, i, snap[i*4 +: 4]);
            end
        end
    endtask

    task automatic test_mode_toggle();
        logic [31:0] snap;
        if_a.mode = 1'b0; if_a.en = 1'b0; if_a.f_ready = 1'b1;
        cycle();
        checks++;
        if (if_a.f_valid !== 1'b0) begin
            failures++;
            $display("FAIL toggle_drain: got v=%0b want 0", if_a.f_valid);
        end
        if_a.mode = 1'b1; if_a.en = 1'b1;
        if_a.w = 32'($urandom); snap = if_a.w;
        cycle();
        checks++;
        if (if_a.f_ch !== 3'd0 || if_a.f !== snap[3:0] || if_a.f_valid !== 1'b1) begin
            failures++;
            $display("FAIL toggle_restart: got ch=%0d f=%0h v=%0b want ch=0 f=%0h v=1", if_a.f_ch, if_a.f, if_a.f_valid, snap[3:0]);
        end
        cycle();
        checks++;
        if (if_a.f_ch !== 3'd1) begin
            failures++;
            $display("FAIL toggle_next: got ch=%0d want 1", if_a.f_ch);
        end
        if_a.f_ready = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        checks++;
        if (if_a.f_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_drop: got v=%0b want 0", if_a.f_valid);
        end
        rst = 1'b0;
        if_a.en = 1'b0;
        if_a.mode = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [23:0] snap;
        if_b.mode = 1'b0; if_b.en = 1'b1; if_b.f_ready = 1'b1;
        if_b.w = 24'($urandom); if_b.s = 3'd7;
        cycle();
        checks++;
        if (if_b.f !== 4'h0 || if_b.sel_err !== 1'b1 || if_b.f_ch !== 3'd7 || if_b.f_valid !== 1'b1) begin
            failures++;
            $display("FAIL oor_s7: got f=%0h e=%0b ch=%0d v=%0b want f=0 e=1 ch=7 v=1", if_b.f, if_b.sel_err, if_b.f_ch, if_b.f_valid);
        end
        if_b.w = 24'($urandom); if_b.s = 3'd1; snap = if_b.w;
        cycle();
        checks++;
        if (if_b.sel_err !== 1'b0 || if_b.f !== snap[7:4] || if_b.f_ch !== 3'd1) begin
            failures++;
            $display("FAIL oor_clear: got e=%0b f=%0h ch=%0d want e=0 f=%0h ch=1", if_b.sel_err, if_b.f, if_b.f_ch, snap[7:4]);
        end
    endtask

    task automatic test_dwell();
        logic [23:0] snap;
        int c;
        if_b.mode = 1'b1; if_b.en = 1'b1; if_b.f_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if_b.w = 24'($urandom); snap = if_b.w;
            c = (i / 2) % 6;
            cycle();
            checks++;
            if (if_b.f_ch !== 3'(c) || if_b.f !== snap[c*4 +: 4]) begin
                failures++;
                $display("FAIL dwell_seq[%0d]: got ch=%0d f=%0h want ch=%0d f=%0h", i, if_b.f_ch, if_b.f, c, snap[c*4 +: 4]);
            end
        end
        if_b.en = 1'b0;
        if_b.mode = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(63) == 0);
            if ($urandom_range(7) == 0) if_a.mode = ~if_a.mode;
            if ($urandom_range(7) == 0) if_b.mode = ~if_b.mode;
            if_a.en = ($urandom_range(3) != 0); if_a.f_ready = ($urandom_range(2) != 0);
            if_b.en = ($urandom_range(3) != 0); if_b.f_ready = ($urandom_range(2) != 0);
            if_a.s = 3'($urandom_range(7)); if_b.s = 3'($urandom_range(7));
            if_a.w = 32'($urandom); if_b.w = 24'($urandom);
            cycle();
            checks++;
            if (if_a.f_valid !== (exp_a_q.size() != 0)) begin
                failures++;
                $display("FAIL rand_a_valid[%0d]: got %0b want %0b", i, if_a.f_valid, exp_a_q.size() != 0);
            end else if (exp_a_q.size() != 0) begin
                checks++;
                if ({if_a.sel_err, if_a.f_ch, if_a.f} !== exp_a_q[0]) begin
                    failures++;
                    $display("FAIL rand_a_word[%0d]: got %0h want %0h", i, {if_a.sel_err, if_a.f_ch, if_a.f}, exp_a_q[0]);
                end
`ifdef MUX_SCAN_PARITY_EN
                checks++;
                if (if_a.f_par !== ^exp_a_q[0][3:0]) begin
                    failures++;
                    $display("FAIL rand_a_par[%0d]: got %0b want %0b", i, if_a.f_par, ^exp_a_q[0][3:0]);
                end
`endif
            end
            checks++;
            if (if_b.f_valid !== (exp_b_q.size() != 0)) begin
                failures++;
                $display("FAIL rand_b_valid[%0d]: got %0b want %0b", i, if_b.f_valid, exp_b_q.size() != 0);
            end else if (exp_b_q.size() != 0) begin
                checks++;
                if ({if_b.sel_err, if_b.f_ch, if_b.f} !== exp_b_q[0]) begin
                    failures++;
                    $display("FAIL rand_b_word[%0d]: got %0h want %0h", i, {if_b.sel_err, if_b.f_ch, if_b.f}, exp_b_q[0]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        if_a.w = '0; if_a.s = '0; if_a.mode = 1'b0; if_a.en = 1'b0; if_a.f_ready = 1'b0;
        if_b.w = '0; if_b.s = '0; if_b.mode = 1'b0; if_b.en = 1'b0; if_b.f_ready = 1'b0;
        test_reset();
        test_direct();
        test_backpressure();
        test_scan();
        test_mode_toggle();
        test_out_of_range();
        test_dwell();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
